// File: rtl/sliding_window_buffer.sv
// K x K x CH sliding-window generator over a raster-order pixel stream.
// Buffers K-1 rows in line memory and emits one registered window per stride-aligned position.
module sliding_window_buffer #(
    parameter int IF_BW  = 8,
    parameter int CH     = 2,
    parameter int K      = 2,
    parameter int STRIDE = 2,
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    localparam int OUT_W = (IN_W - K) / STRIDE + 1,
    localparam int OUT_H = (IN_H - K) / STRIDE + 1,
    localparam int PW    = CH * IF_BW,
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int XW    = (IN_W > 1) ? $clog2(IN_W) : 1,
    localparam int YW    = (IN_H > 1) ? $clog2(IN_H) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [PW-1:0]         i_in_pixel,
    output logic                  o_window_valid,
    input  logic                  i_window_ready,
    output logic [K*K*PW-1:0]     o_window,
    output logic [CW-1:0]         o_win_col,
    output logic [RW-1:0]         o_win_row,
    output logic                  o_frame_done
);

    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [PW-1:0]     line_mem [K-1][IN_W];
    logic [PW-1:0]     win_sr   [K][K];
    logic [PW-1:0]     win_nx   [K][K];
    logic [K*K*PW-1:0] win_flat;
    logic              accept;
    logic              x_last;
    logic              y_last;
    logic              emit;
    int                x_off;
    int                y_off;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; a source holds valid and data until that transfer.
    // Input is refused only while a window is waiting on a stalled consumer.
    assign o_in_ready = !(o_window_valid && !i_window_ready);
    assign accept     = i_in_valid && o_in_ready;
    assign x_last     = (x_cnt == XW'(IN_W - 1));
    assign y_last     = (y_cnt == YW'(IN_H - 1));

    always_comb begin
        x_off = int'(x_cnt) - (K - 1);
        y_off = int'(y_cnt) - (K - 1);
        emit  = accept && (x_off >= 0) && (y_off >= 0) &&
                (x_off % STRIDE == 0) && (y_off % STRIDE == 0);
    end

    // Post-shift window: columns move left, new right column comes from the
    // line memory (read before its update) topped off by the incoming pixel.
    always_comb begin
        for (int wy = 0; wy < K; wy++) begin
            for (int wx = 0; wx < K - 1; wx++) begin
                win_nx[wy][wx] = win_sr[wy][wx+1];
            end
        end
        for (int wy = 0; wy < K - 1; wy++) begin
            win_nx[wy][K-1] = line_mem[wy][x_cnt];
        end
        win_nx[K-1][K-1] = i_in_pixel;
    end

    always_comb begin
        win_flat = '0;
        for (int wy = 0; wy < K; wy++) begin
            for (int wx = 0; wx < K; wx++) begin
                win_flat[(wy*K+wx)*PW +: PW] = win_nx[wy][wx];
            end
        end
    end

    // Data-path storage needs no reset: emission only happens once a frame has
    // refilled every row and column the window reads.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int j = 0; j < K - 2; j++) begin
                line_mem[j][x_cnt] <= line_mem[j+1][x_cnt];
            end
            line_mem[K-2][x_cnt] <= i_in_pixel;
            for (int wy = 0; wy < K; wy++) begin
                for (int wx = 0; wx < K; wx++) begin
                    win_sr[wy][wx] <= win_nx[wy][wx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt          <= '0;
            y_cnt          <= '0;
            o_window_valid <= 1'b0;
            o_window       <= '0;
            o_win_col      <= '0;
            o_win_row      <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            o_frame_done <= accept && x_last && y_last;
            if (accept) begin
                if (x_last) begin
                    x_cnt <= '0;
                    y_cnt <= y_last ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
            if (emit) begin
                o_window_valid <= 1'b1;
                o_window       <= win_flat;
                o_win_col      <= CW'(x_off / STRIDE);
                o_win_row      <= RW'(y_off / STRIDE);
            end else if (o_window_valid && i_window_ready) begin
                o_window_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer: default 2x2/stride-2 instance plus a 3x3/stride-1 instance.
module tb_sliding_window_buffer;

    logic        clk;
    logic        reset;
    logic        d_valid, d_in_ready, d_wvalid, d_wready, d_fd;
    logic [15:0] d_pixel;
    logic [63:0] d_window;
    logic [1:0]  d_col, d_row;
    logic        k3_valid, k3_in_ready, k3_wvalid, k3_wready, k3_fd;
    logic [7:0]  k3_pixel;
    logic [71:0] k3_window;
    logic [1:0]  k3_col, k3_row;

    int total, bad, cyc;
    int fd_cnt, k3_fd_cnt;
    logic fd_with_last;
    logic [63:0] act_q[$];
    logic [3:0]  act_pos_q[$];
    logic [63:0] exp_q[$];
    logic [3:0]  exp_pos_q[$];
    logic [71:0] k3_act_q[$];
    logic [3:0]  k3_pos_q[$];

    sliding_window_buffer dut (
        .clk(clk), .reset(reset),
        .i_in_valid(d_valid), .o_in_ready(d_in_ready), .i_in_pixel(d_pixel),
        .o_window_valid(d_wvalid), .i_window_ready(d_wready), .o_window(d_window),
        .o_win_col(d_col), .o_win_row(d_row), .o_frame_done(d_fd)
    );

    sliding_window_buffer #(.IF_BW(8), .CH(1), .K(3), .STRIDE(1), .IN_W(5), .IN_H(5)) dut_k3 (
        .clk(clk), .reset(reset),
        .i_in_valid(k3_valid), .o_in_ready(k3_in_ready), .i_in_pixel(k3_pixel),
        .o_window_valid(k3_wvalid), .i_window_ready(k3_wready), .o_window(k3_window),
        .o_win_col(k3_col), .o_win_row(k3_row), .o_frame_done(k3_fd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: record every completed window handshake and frame_done pulse
    initial begin
        fd_cnt = 0;
        k3_fd_cnt = 0;
        fd_with_last = 1'b0;
    end
    always @(negedge clk) begin
        if (!reset && d_wvalid && d_wready) begin
            act_q.push_back(d_window);
            act_pos_q.push_back({d_row, d_col});
        end
        if (d_fd) begin
            fd_cnt = fd_cnt + 1;
            fd_with_last = d_wvalid && (d_col == 2'd3) && (d_row == 2'd3);
        end
        if (!reset && k3_wvalid && k3_wready) begin
            k3_act_q.push_back(k3_window);
            k3_pos_q.push_back({k3_row, k3_col});
        end
        if (k3_fd) k3_fd_cnt = k3_fd_cnt + 1;
    end

    // reference model
    function automatic logic [15:0] pix(input int idx, input int off);
        logic [7:0] c0;
        c0 = 8'(idx + off);
        return {c0 + 8'd100, c0};
    endfunction

    function automatic logic [63:0] exp_win(input int c, input int r, input int off);
        logic [63:0] w;
        w = '0;
        for (int wy = 0; wy < 2; wy++)
            for (int wx = 0; wx < 2; wx++)
                w[(wy*2+wx)*16 +: 16] = pix((r*2+wy)*8 + c*2 + wx, off);
        return w;
    endfunction

    function automatic logic [71:0] k3_exp(input int c, input int r);
        logic [71:0] w;
        w = '0;
        for (int wy = 0; wy < 3; wy++)
            for (int wx = 0; wx < 3; wx++)
                w[(wy*3+wx)*8 +: 8] = 8'((r+wy)*5 + c + wx);
        return w;
    endfunction

    task automatic push_frame_exp(input int off);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back(exp_win(c, r, off));
                exp_pos_q.push_back({2'(r), 2'(c)});
            end
    endtask

    // drivers
    task automatic reset_dut();
        reset = 1'b1;
        d_valid = 1'b0; d_wready = 1'b1; d_pixel = '0;
        k3_valid = 1'b0; k3_wready = 1'b1; k3_pixel = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // mode 0: continuous valid, ready held high; mode 2: random gaps and random ready
    task automatic drive_pixels(input int first, input int last, input int off, input int mode);
        int idx = first;
        int budget = 0;
        logic acc;
        while (idx <= last && budget < 5000) begin
            d_valid  = (mode == 2) ? ($urandom_range(0, 99) < 70) : 1'b1;
            d_wready = (mode == 2) ? ($urandom_range(0, 99) < 70) : 1'b1;
            d_pixel  = pix(idx, off);
            #1 acc = d_valid && d_in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            budget++;
        end
        d_valid = 1'b0;
        if (budget >= 5000) begin
            total++; bad++;
            $display("FAIL drive_timeout: stuck at pixel %0d, required reach %0d", idx, last);
        end
    endtask

    task automatic drain();
        d_valid = 1'b0;
        d_wready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // tests
    task automatic test_reset();
        reset_dut();
        total++; if (d_wvalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", d_wvalid); end
        total++; if (d_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", d_in_ready); end
        total++; if (d_window !== 64'h0) begin bad++; $display("FAIL rst_window: got %h want 0", d_window); end
        total++; if ({d_row, d_col} !== 4'h0) begin bad++; $display("FAIL rst_coord: got %h want 0", {d_row, d_col}); end
        total++; if (d_fd !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", d_fd); end
        total++; if (k3_wvalid !== 1'b0 || k3_in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_k3: valid=%b ready=%b want 0/1", k3_wvalid, k3_in_ready);
        end
    endtask

    task automatic test_full_frame();
        int a0, f0, c0, n;
        reset_dut();
        a0 = act_q.size(); f0 = fd_cnt;
        exp_q.delete(); exp_pos_q.delete();
        push_frame_exp(0);
        c0 = cyc;
        drive_pixels(0, 63, 0, 0);
        total++; if (cyc - c0 !== 64) begin bad++; $display("FAIL full_throughput: got %0d cycles want 64", cyc - c0); end
        drain();
        n = act_q.size() - a0;
        total++; if (n !== 16) begin bad++; $display("FAIL full_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++;
            if (act_q[a0+i] !== exp_q[i] || act_pos_q[a0+i] !== exp_pos_q[i]) begin
                bad++; $display("FAIL full_win%0d: got %h/%h want %h/%h", i, act_q[a0+i], act_pos_q[a0+i], exp_q[i], exp_pos_q[i]);
            end
        end
        if (n == 16) begin
            total++; if (act_q[a0] !== 64'h6D096C0865016400) begin bad++; $display("FAIL full_first: got %h want 6d096c0865016400", act_q[a0]); end
            total++; if (act_q[a0+15] !== 64'hA33FA23E9B379A36 || act_pos_q[a0+15] !== 4'hF) begin
                bad++; $display("FAIL full_last: got %h/%h want a33fa23e9b379a36/f", act_q[a0+15], act_pos_q[a0+15]);
            end
        end
        total++; if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL full_frame_done: got %0d want 1", fd_cnt - f0); end
        total++; if (fd_with_last !== 1'b1) begin bad++; $display("FAIL full_fd_align: got %b want 1", fd_with_last); end
    endtask

    task automatic test_backpressure();
        int a0, f0, n;
        logic [63:0] held;
        reset_dut();
        a0 = act_q.size(); f0 = fd_cnt;
        exp_q.delete(); exp_pos_q.delete();
        push_frame_exp(0);
        drive_pixels(0, 8, 0, 0);
        total++; if (d_wvalid !== 1'b0) begin bad++; $display("FAIL bp_early_valid: got %b want 0", d_wvalid); end
        drive_pixels(9, 9, 0, 0);
        total++; if (d_wvalid !== 1'b1) begin bad++; $display("FAIL bp_latency: got %b want 1", d_wvalid); end
        total++; if (d_window !== 64'h6D096C0865016400 || {d_row, d_col} !== 4'h0) begin
            bad++; $display("FAIL bp_first: got %h/%h want 6d096c0865016400/0", d_window, {d_row, d_col});
        end
        d_wready = 1'b0; d_valid = 1'b1; d_pixel = pix(10, 0);
        held = d_window;
        for (int s = 0; s < 5; s++) begin
            #1;
            total++; if (d_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", s, d_in_ready); end
            @(posedge clk);
            #1;
            total++; if (d_window !== held || d_wvalid !== 1'b1 || {d_row, d_col} !== 4'h0) begin
                bad++; $display("FAIL bp_hold%0d: got %h v=%b want %h v=1", s, d_window, d_wvalid, held);
            end
        end
        drive_pixels(10, 63, 0, 0);
        drain();
        n = act_q.size() - a0;
        total++; if (n !== 16) begin bad++; $display("FAIL bp_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++;
            if (act_q[a0+i] !== exp_q[i] || act_pos_q[a0+i] !== exp_pos_q[i]) begin
                bad++; $display("FAIL bp_win%0d: got %h/%h want %h/%h", i, act_q[a0+i], act_pos_q[a0+i], exp_q[i], exp_pos_q[i]);
            end
        end
        total++; if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL bp_frame_done: got %0d want 1", fd_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int a0, f0, n;
        reset_dut();
        drive_pixels(0, 43, 50, 0);
        total++; if (d_wvalid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", d_wvalid); end
        d_wready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        total++; if (d_wvalid !== 1'b0 || d_window !== 64'h0 || d_in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_dropped: v=%b win=%h rdy=%b want 0/0/1", d_wvalid, d_window, d_in_ready);
        end
        a0 = act_q.size(); f0 = fd_cnt;
        exp_q.delete(); exp_pos_q.delete();
        push_frame_exp(0);
        drive_pixels(0, 63, 0, 0);
        drain();
        n = act_q.size() - a0;
        total++; if (n !== 16) begin bad++; $display("FAIL mid_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++;
            if (act_q[a0+i] !== exp_q[i] || act_pos_q[a0+i] !== exp_pos_q[i]) begin
                bad++; $display("FAIL mid_win%0d: got %h/%h want %h/%h", i, act_q[a0+i], act_pos_q[a0+i], exp_q[i], exp_pos_q[i]);
            end
        end
        total++; if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL mid_frame_done: got %0d want 1", fd_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int a0, f0, n;
        reset_dut();
        a0 = act_q.size(); f0 = fd_cnt;
        exp_q.delete(); exp_pos_q.delete();
        push_frame_exp(0);
        push_frame_exp(50);
        drive_pixels(0, 63, 0, 0);
        drive_pixels(0, 63, 50, 0);
        drain();
        n = act_q.size() - a0;
        total++; if (n !== 32) begin bad++; $display("FAIL b2b_count: got %0d want 32", n); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++;
            if (act_q[a0+i] !== exp_q[i] || act_pos_q[a0+i] !== exp_pos_q[i]) begin
                bad++; $display("FAIL b2b_win%0d: got %h/%h want %h/%h", i, act_q[a0+i], act_pos_q[a0+i], exp_q[i], exp_pos_q[i]);
            end
        end
        total++; if (fd_cnt - f0 !== 2) begin bad++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt - f0); end
    endtask

    task automatic test_k3();
        int k0, f0, n, idx, budget;
        logic acc;
        reset_dut();
        k0 = k3_act_q.size(); f0 = k3_fd_cnt;
        idx = 0; budget = 0;
        while (idx < 25 && budget < 200) begin
            k3_valid = 1'b1;
            k3_pixel = 8'(idx);
            #1 acc = k3_valid && k3_in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            budget++;
        end
        k3_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (idx !== 25) begin bad++; $display("FAIL k3_drive: got %0d pixels want 25", idx); end
        n = k3_act_q.size() - k0;
        total++; if (n !== 9) begin bad++; $display("FAIL k3_count: got %0d want 9", n); end
        for (int i = 0; i < n && i < 9; i++) begin
            total++;
            if (k3_act_q[k0+i] !== k3_exp(i % 3, i / 3) || k3_pos_q[k0+i] !== {2'(i / 3), 2'(i % 3)}) begin
                bad++; $display("FAIL k3_win%0d: got %h/%h want %h", i, k3_act_q[k0+i], k3_pos_q[k0+i], k3_exp(i % 3, i / 3));
            end
        end
        if (n == 9) begin
            total++; if (k3_act_q[k0+7] !== 72'h171615121110_0D0C0B || k3_pos_q[k0+7] !== 4'b1001) begin
                bad++; $display("FAIL k3_win_c1_r2: got %h/%h want 1716151211100d0c0b/9", k3_act_q[k0+7], k3_pos_q[k0+7]);
            end
        end
        total++; if (k3_fd_cnt - f0 !== 1) begin bad++; $display("FAIL k3_frame_done: got %0d want 1", k3_fd_cnt - f0); end
    endtask

    task automatic test_random();
        int a0, f0, n, c0, fr;
        reset_dut();
        a0 = act_q.size(); f0 = fd_cnt;
        exp_q.delete(); exp_pos_q.delete();
        c0 = cyc; fr = 0;
        while (cyc - c0 < 2000 && fr < 30) begin
            push_frame_exp(fr * 3);
            drive_pixels(0, 63, fr * 3, 2);
            fr++;
        end
        drain();
        n = act_q.size() - a0;
        total++; if (n !== 16 * fr) begin bad++; $display("FAIL rnd_count: got %0d want %0d", n, 16 * fr); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++;
            if (act_q[a0+i] !== exp_q[i] || act_pos_q[a0+i] !== exp_pos_q[i]) begin
                bad++; $display("FAIL rnd_win%0d: got %h/%h want %h/%h", i, act_q[a0+i], act_pos_q[a0+i], exp_q[i], exp_pos_q[i]);
            end
        end
        total++; if (fd_cnt - f0 !== fr) begin bad++; $display("FAIL rnd_frame_done: got %0d want %0d", fd_cnt - f0, fr); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        d_valid = 1'b0; d_wready = 1'b1; d_pixel = '0;
        k3_valid = 1'b0; k3_wready = 1'b1; k3_pixel = '0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_k3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
